ddr_input_conditioner: RTL and testbench



---
 rtl/ddr_input_pkg.sv | 20 ++
 rtl/button_debounce.sv | 49 ++++
 rtl/ddr_input_conditioner.sv | 83 ++++++++
 tb/tb_ddr_input_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_input_pkg.sv
// Shared codes and indices for the DDR push-button front-end.
// Speed encodings match the scroll-speed field consumed by the game logic.
package ddr_input_pkg;

    typedef enum logic [1:0] {
        SPEED_SLOW   = 2'b00,
        SPEED_NORMAL = 2'b01,
        SPEED_FAST   = 2'b10
    } speed_e;

    localparam int ARROW_UP    = 0;
    localparam int ARROW_DOWN  = 1;
    localparam int ARROW_LEFT  = 2;
    localparam int ARROW_RIGHT = 3;

    localparam int NUM_ARROWS   = 4;
    localparam int NUM_SPEEDS   = 3;
    localparam int NUM_CHANNELS = NUM_ARROWS + NUM_SPEEDS;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, run-length debounce counter,
// debounced level and a registered one-cycle pulse on each debounced rise.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            // Any sample agreeing with the stable state restarts the run.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
                rise_reg   <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = stable_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/ddr_input_conditioner.sv
// Conditions the four arrow and three speed push-buttons: per-channel debounce,
// arrow press pulses, and a priority speed latch with a change strobe.
module ddr_input_conditioner
    import ddr_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       slow,
    input  logic       normal,
    input  logic       fast,
    output logic [3:0] arrow_level,
    output logic [3:0] arrow_press,
    output logic       any_press,
    output logic [1:0] speed_sel,
    output logic       speed_change
);

    // Channels 0..3 are the arrows in output bit order; 4..6 are slow/normal/fast.
    logic [NUM_CHANNELS-1:0] raw_btn;
    logic [NUM_CHANNELS-1:0] level_vec;
    logic [NUM_CHANNELS-1:0] rise_vec;

    assign raw_btn = {fast, normal, slow, RIGHT, LEFT, DOWN, UP};

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .btn_in(raw_btn[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    // Speed buttons act only through their rise pulses.
    logic unused_speed_levels;
    assign unused_speed_levels = ^level_vec[NUM_CHANNELS-1:NUM_ARROWS];

    assign arrow_level = level_vec[NUM_ARROWS-1:0];
    assign arrow_press = rise_vec[NUM_ARROWS-1:0];
    assign any_press   = |rise_vec[NUM_ARROWS-1:0];

    speed_e speed_sel_reg;
    speed_e speed_next;
    logic   speed_change_reg;

    always_comb begin
        speed_next = speed_sel_reg;
        if (rise_vec[NUM_ARROWS+2]) begin
            speed_next = SPEED_FAST;
        end else if (rise_vec[NUM_ARROWS+1]) begin
            speed_next = SPEED_NORMAL;
        end else if (rise_vec[NUM_ARROWS]) begin
            speed_next = SPEED_SLOW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_sel_reg    <= SPEED_NORMAL;
            speed_change_reg <= 1'b0;
        end else begin
            speed_sel_reg    <= speed_next;
            speed_change_reg <= (speed_next != speed_sel_reg);
        end
    end

    assign speed_sel    = speed_sel_reg;
    assign speed_change = speed_change_reg;

endmodule

// File: tb/tb_ddr_input_conditioner.sv
// Randomised and directed stimulus for ddr_input_conditioner, scored every cycle
// against a sample-history reference model through an expected-output queue.
module tb_ddr_input_conditioner;

    localparam int DEB = 4;
    localparam int NCH = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] btn = '0;
    logic [3:0] arrow_level;
    logic [3:0] arrow_press;
    logic       any_press;
    logic [1:0] speed_sel;
    logic       speed_change;

    always #5 clk = ~clk;

    ddr_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .UP          (btn[0]),
        .DOWN        (btn[1]),
        .LEFT        (btn[2]),
        .RIGHT       (btn[3]),
        .slow        (btn[4]),
        .normal      (btn[5]),
        .fast        (btn[6]),
        .arrow_level (arrow_level),
        .arrow_press (arrow_press),
        .any_press   (any_press),
        .speed_sel   (speed_sel),
        .speed_change(speed_change)
    );

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic       any;
        logic [1:0] speed;
        logic       change;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: raw samples reach the debouncer two edges late; a channel
    // flips when its last DEB delayed samples all disagree with its stable value.
    logic       raw_hist [NCH][2];
    logic       dly_hist [NCH][DEB];
    logic [6:0] stable_m;
    logic [2:0] spd_rise_m;
    logic [1:0] speed_m;

    task automatic model_step();
        exp_t       e;
        logic [6:0] rise;
        logic [1:0] new_speed;
        logic       d;
        logic       all_diff;
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                raw_hist[c][0] = 1'b0;
                raw_hist[c][1] = 1'b0;
                for (int j = 0; j < DEB; j++) dly_hist[c][j] = 1'b0;
            end
            stable_m   = '0;
            spd_rise_m = '0;
            speed_m    = 2'b01;
            e = '{level: 4'h0, press: 4'h0, any: 1'b0, speed: 2'b01, change: 1'b0};
        end else begin
            rise = '0;
            for (int c = 0; c < NCH; c++) begin
                d = raw_hist[c][1];
                raw_hist[c][1] = raw_hist[c][0];
                raw_hist[c][0] = btn[c];
                for (int j = DEB - 1; j > 0; j--) dly_hist[c][j] = dly_hist[c][j-1];
                dly_hist[c][0] = d;
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (dly_hist[c][j] == stable_m[c]) all_diff = 1'b0;
                if (all_diff) begin
                    rise[c]     = ~stable_m[c];
                    stable_m[c] = ~stable_m[c];
                end
            end
            new_speed = speed_m;
            if (spd_rise_m[2])      new_speed = 2'b10;
            else if (spd_rise_m[1]) new_speed = 2'b01;
            else if (spd_rise_m[0]) new_speed = 2'b00;
            e.change   = (new_speed != speed_m);
            speed_m    = new_speed;
            e.speed    = new_speed;
            spd_rise_m = rise[6:4];
            e.level    = stable_m[3:0];
            e.press    = rise[3:0];
            e.any      = |rise[3:0];
        end
        sb_q.push_back(e);
    endtask

    // Each call covers one clock: model the edge, then return at the falling edge
    // so the caller drives inputs away from the active edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t want;
        exp_t got;
        #1;
        got = '{level: arrow_level, press: arrow_press, any: any_press,
                speed: speed_sel, change: speed_change};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got=%b required=an expected entry", $time, got);
        end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL outputs t=%0t got level=%b press=%b any=%b speed=%b change=%b required level=%b press=%b any=%b speed=%b change=%b",
                         $time, got.level, got.press, got.any, got.speed, got.change,
                         want.level, want.press, want.any, want.speed, want.change);
            end else if (want.press != 0 || want.change) begin
                $display("event t=%0t press=%b any=%b speed=%b change=%b", $time,
                         got.press, got.any, got.speed, got.change);
            end
        end
    end

    initial begin
        int hold;
        reset = 1'b0;
        btn   = '0;
        tick(3);
        reset = 1'b1;
        tick(20);

        btn[0] = 1'b1;                       // UP press and hold, then release
        tick(14);
        btn[0] = 1'b0;
        tick(10);

        for (int r = 0; r < 4; r++) begin    // LEFT bounce 3-high / 1-low
            btn[2] = 1'b1;
            tick(3);
            btn[2] = 1'b0;
            tick(1);
        end
        tick(8);

        btn = 7'b0001001;                    // UP + RIGHT chord
        tick(10);
        btn = '0;
        tick(10);

        btn[6] = 1'b1; tick(10); btn[6] = 1'b0; tick(10);   // fast
        btn[6] = 1'b1; tick(10); btn[6] = 1'b0; tick(10);   // fast again
        btn[5] = 1'b1; tick(10); btn[5] = 1'b0; tick(10);   // back to normal
        btn[4] = 1'b1; btn[6] = 1'b1; tick(10);             // slow + fast together
        btn = '0;
        tick(10);

        btn[1] = 1'b1;                       // DOWN held across a reset pulse
        tick(2);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(14);
        btn[1] = 1'b0;
        tick(10);

        for (int s = 0; s < 400; s++) begin
            btn  = 7'($urandom);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
            tick(hold);
        end
        btn = '0;
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
